// File: rtl/rom_loader_if.sv
// rom_loader_if -- byte-stream and instruction-memory write bundle for rom_loader.
//
// Parameter DEPTH sets the instruction-memory depth in words, which fixes the
// write-address width AW = $clog2(DEPTH). WIDTH is the instruction width and is
// 16 bits (two stream bytes per word).
//
// Signals:
//   i_Start       single-cycle request to begin a load
//   i_Byte        received byte
//   i_Byte_Valid  i_Byte is valid this cycle
//   o_Byte_Ready  loader accepts a byte this cycle
//   o_Wr_En       instruction-memory write strobe
//   o_Wr_Addr     write address (AW bits)
//   o_Wr_Data     write data (WIDTH bits)
//   o_Cpu_Rst     active-high CPU hold-in-reset
//   o_Busy        load in progress
//   o_Done        last load completed successfully (sticky)
//   o_Error       last load failed (sticky)
//
// Modports: master = byte source / system side, slave = the loader.
interface rom_loader_if #(
  parameter int DEPTH = 2**15,
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             i_Start;
  logic [7:0]       i_Byte;
  logic             i_Byte_Valid;
  logic             o_Byte_Ready;
  logic             o_Wr_En;
  logic [AW-1:0]    o_Wr_Addr;
  logic [WIDTH-1:0] o_Wr_Data;
  logic             o_Cpu_Rst;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Error;

  modport master (
    output i_Start, i_Byte, i_Byte_Valid,
    input  o_Byte_Ready, o_Wr_En, o_Wr_Addr, o_Wr_Data,
    input  o_Cpu_Rst, o_Busy, o_Done, o_Error
  );

  modport slave (
    input  i_Start, i_Byte, i_Byte_Valid,
    output o_Byte_Ready, o_Wr_En, o_Wr_Addr, o_Wr_Data,
    output o_Cpu_Rst, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader -- loads a program into the Hack instruction memory from a byte stream.
//
// On i_Start the CPU is held in reset and a length-prefixed big-endian stream
// is parsed: LEN_HI, LEN_LO (word count N), then N words as HI, LO byte pairs.
// Each word is written to consecutive addresses starting at 0, after which the
// CPU is released. Until the first load the preloaded memory image runs as-is.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to expect one trailing byte
// equal to the 8-bit sum of all data bytes; a mismatch ends the load in ERROR.
//
// Ports:
//   i_Clk    system clock, all state on the rising edge
//   i_Rst_n  asynchronous active-low reset; aborts any load and returns to IDLE
//   bus      rom_loader_if.slave: byte stream in, memory write port and status out
//
// All outputs are registered from the next-state value, so there is no
// combinational path from i_Byte_Valid to any output.
module rom_loader #(
  parameter int DEPTH = 2**15,
  parameter int WIDTH = 16
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  rom_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_word;
  // Word index is 16 bits so a full-depth load (N == DEPTH) still terminates.
  logic [15:0] index;
  logic        accept;
  logic        last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign accept    = bus.i_Byte_Valid & bus.o_Byte_Ready;
  assign len_word  = {len_hi, bus.i_Byte};
  assign last_word = (index == len - 16'd1);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (bus.i_Start) state_nxt = ST_LEN_HI;
      ST_LEN_HI:
        if (accept) state_nxt = ST_LEN_LO;
      ST_LEN_LO:
        if (accept) begin
          if (len_word == 16'd0 || {1'b0, len_word} > DEPTH_W) state_nxt = ST_ERROR;
          else                                                 state_nxt = ST_DATA_HI;
        end
      ST_DATA_HI:
        if (accept) state_nxt = ST_DATA_LO;
      ST_DATA_LO:
        if (accept) state_nxt = ST_WRITE;
      ST_WRITE:
`ifdef ROM_LOADER_CHECKSUM_EN
        state_nxt = last_word ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:
        if (accept) state_nxt = (bus.i_Byte == sum) ? ST_DONE : ST_ERROR;
`else
        state_nxt = last_word ? ST_DONE : ST_DATA_HI;
`endif
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state            <= ST_IDLE;
      len_hi           <= '0;
      len              <= '0;
      index            <= '0;
      bus.o_Byte_Ready <= 1'b0;
      bus.o_Wr_En      <= 1'b0;
      bus.o_Wr_Addr    <= '0;
      bus.o_Wr_Data    <= '0;
      bus.o_Cpu_Rst    <= 1'b0;
      bus.o_Busy       <= 1'b0;
      bus.o_Done       <= 1'b0;
      bus.o_Error      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      state <= state_nxt;

      // Status outputs are decoded from the next state and registered, so they
      // change on the same edge as the state itself.
      bus.o_Byte_Ready <= state_nxt inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO
`ifdef ROM_LOADER_CHECKSUM_EN
                                            , ST_CHECK
`endif
                                           };
      bus.o_Wr_En   <= (state_nxt == ST_WRITE);
      // CPU stays held in ERROR: a failed load leaves a partial image behind.
      bus.o_Cpu_Rst <= !(state_nxt inside {ST_IDLE, ST_DONE});
      bus.o_Busy    <= !(state_nxt inside {ST_IDLE, ST_DONE, ST_ERROR});
      bus.o_Done    <= (state_nxt == ST_DONE);
      bus.o_Error   <= (state_nxt == ST_ERROR);

      // Address is captured on entry to WRITE; index only advances inside WRITE.
      if (state_nxt == ST_WRITE) bus.o_Wr_Addr <= index[AW-1:0];

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR:
          if (bus.i_Start) begin
            index <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        ST_LEN_HI:
          if (accept) len_hi <= bus.i_Byte;
        ST_LEN_LO:
          if (accept) len <= len_word;
        ST_DATA_HI:
          if (accept) begin
            bus.o_Wr_Data[WIDTH-1:8] <= bus.i_Byte;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum <= sum + bus.i_Byte;
`endif
          end
        ST_DATA_LO:
          if (accept) begin
            bus.o_Wr_Data[7:0] <= bus.i_Byte;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum <= sum + bus.i_Byte;
`endif
          end
        ST_WRITE:
          if (!last_word) index <= index + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader -- self-checking bench for rom_loader.
//
// A reference model derives the expected write list and final status directly
// from the byte stream; a negedge monitor records every write strobe.
// Define ROM_LOADER_CHECKSUM_EN for both RTL and bench to cover the checksum build.
module tb_rom_loader;
  localparam int DEPTH = 2**15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_loader_if #(.DEPTH(DEPTH)) bus ();

  rom_loader #(.DEPTH(DEPTH)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  int got_addr[$];
  int got_data[$];
  int exp_addr[$];
  int exp_data[$];
  int ref_addr[$];
  int ref_data[$];
  logic [7:0] stream[$];
  int  words[$];
  bit  exp_done;
  bit  jitter = 1'b0;
  int  overlap = 0;
  time last_wr_time = 0;

  // Write monitor: one entry per cycle with the strobe high.
  always @(negedge clk) begin
    if (bus.o_Wr_En === 1'b1) begin
      got_addr.push_back(int'(bus.o_Wr_Addr));
      got_data.push_back(int'(bus.o_Wr_Data));
      last_wr_time = $time;
      if (bus.o_Byte_Ready !== 1'b0) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream = 16-bit count, then each word HI/LO, then the checksum byte if enabled.
  task automatic build_stream();
    int s = 0;
    stream.delete();
    stream.push_back(8'(words.size() >> 8));
    stream.push_back(8'(words.size()));
    foreach (words[i]) begin
      stream.push_back(8'(words[i] >> 8));
      stream.push_back(8'(words[i]));
      s += (words[i] >> 8) + (words[i] & 8'hff);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    stream.push_back(8'(s));
`endif
  endtask

  // Expected behaviour computed straight from the stream format rules.
  task automatic model();
    int n;
    int s = 0;
    exp_addr.delete();
    exp_data.delete();
    n = (int'(stream[0]) << 8) | int'(stream[1]);
    if (n == 0 || n > DEPTH) begin
      exp_done = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(i);
        exp_data.push_back((int'(stream[2 + 2*i]) << 8) | int'(stream[3 + 2*i]));
        s += int'(stream[2 + 2*i]) + int'(stream[3 + 2*i]);
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      exp_done = (int'(stream[2 + 2*n]) == (s % 256));
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    bus.i_Start      = 1'b1;
    bus.i_Byte_Valid = 1'b0;
    @(negedge clk);
    bus.i_Start = 1'b0;
    check({tag, "_start_busy"},  32'(bus.o_Busy),       32'd1);
    check({tag, "_start_cpurst"}, 32'(bus.o_Cpu_Rst),   32'd1);
    check({tag, "_start_ready"}, 32'(bus.o_Byte_Ready), 32'd1);
  endtask

  // Presents one byte until accepted; in jitter mode valid is high 1-in-3
  // cycles, junk rides on idle cycles and stray start pulses are injected.
  task automatic send_byte(input logic [7:0] b);
    int  waited = 0;
    bit  took = 1'b0;
    while (!took && waited < 400) begin
      @(negedge clk);
      bus.i_Start      = 1'b0;
      bus.i_Byte_Valid = jitter ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (jitter && $urandom_range(0, 7) == 0) bus.i_Start = 1'b1;
      bus.i_Byte = (jitter && !bus.i_Byte_Valid) ? 8'($urandom) : b;
      took = bus.i_Byte_Valid && (bus.o_Byte_Ready === 1'b1);
      waited++;
    end
    if (!took) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.i_Byte_Valid = 1'b0;
    bus.i_Start      = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int w = 0;
    while (!(bus.o_Done === 1'b1 || bus.o_Error === 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_end_timeout"}, 32'(w < 100), 32'd1);
  endtask

  task automatic run_load(input string tag, input int nbytes);
    got_addr.delete();
    got_data.delete();
    do_start(tag);
    for (int i = 0; i < nbytes; i++) send_byte(stream[i]);
    idle_inputs();
  endtask

  task automatic compare_image(input string tag);
    int m;
    model();
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
    check({tag, "_done"},   32'(bus.o_Done),    32'(exp_done));
    check({tag, "_error"},  32'(bus.o_Error),   32'(!exp_done));
    check({tag, "_cpurst"}, 32'(bus.o_Cpu_Rst), 32'(!exp_done));
    check({tag, "_busy"},   32'(bus.o_Busy),    32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    bus.i_Start      = 1'b0;
    bus.i_Byte       = 8'h00;
    bus.i_Byte_Valid = 1'b0;
    rst_n            = 1'b0;

    // Reset state, then 100 quiet cycles with no byte acceptance.
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(bus.o_Byte_Ready), 32'd0);
    check("rst_wren",   32'(bus.o_Wr_En),      32'd0);
    check("rst_addr",   32'(bus.o_Wr_Addr),    32'd0);
    check("rst_data",   32'(bus.o_Wr_Data),    32'd0);
    check("rst_cpurst", 32'(bus.o_Cpu_Rst),    32'd0);
    check("rst_busy",   32'(bus.o_Busy),       32'd0);
    check("rst_done",   32'(bus.o_Done),       32'd0);
    check("rst_error",  32'(bus.o_Error),      32'd0);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_Byte_Ready !== 1'b0 || bus.o_Wr_En !== 1'b0 || bus.o_Cpu_Rst !== 1'b0) rdy_seen++;
    end
    check("quiet_100", 32'(rdy_seen), 32'd0);

    // Directed two-word load.
    words = '{16'hABCD, 16'h1234};
    build_stream();
    run_load("two", stream.size());
    wait_end("two");
`ifndef ROM_LOADER_CHECKSUM_EN
    check("two_done_latency", 32'($time - last_wr_time), 32'd10);
`endif
    compare_image("two");

    // Illegal lengths: zero and DEPTH+1.
    stream = '{8'h00, 8'h00};
    run_load("len0", 2);
    wait_end("len0");
    compare_image("len0");
    stream = '{8'h80, 8'h01};
    run_load("lenbig", 2);
    wait_end("lenbig");
    compare_image("lenbig");

    // N == DEPTH is legal: loader must move on to data, not error.
    stream = '{8'h80, 8'h00};
    run_load("lenmax", 2);
    check("lenmax_error", 32'(bus.o_Error),      32'd0);
    check("lenmax_ready", 32'(bus.o_Byte_Ready), 32'd1);
    check("lenmax_busy",  32'(bus.o_Busy),       32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ROM_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
    run_load("cs_good", 5);
    wait_end("cs_good");
    compare_image("cs_good");
    stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04};
    run_load("cs_bad", 5);
    wait_end("cs_bad");
    compare_image("cs_bad");
`endif

    // Random image: back-to-back, then jittered with stray start pulses.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(int'($urandom_range(0, 16'hFFFF)));
    build_stream();
    run_load("b2b", stream.size());
    wait_end("b2b");
    compare_image("b2b");
    ref_addr = got_addr;
    ref_data = got_data;
    jitter = 1'b1;
    run_load("jit", stream.size());
    jitter = 1'b0;
    wait_end("jit");
    compare_image("jit");
    check("jit_vs_b2b_n", 32'(got_addr.size()), 32'(ref_addr.size()));
    foreach (ref_data[i])
      if (i < got_data.size()) check($sformatf("jit_vs_b2b_%0d", i), 32'(got_data[i]), 32'(ref_data[i]));
    check("wr_ready_overlap", 32'(overlap), 32'd0);

    // Reset between the HI and LO bytes of word 5.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(int'($urandom_range(0, 16'hFFFF)));
    build_stream();
    run_load("abort", 13);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cpurst", 32'(bus.o_Cpu_Rst),    32'd0);
    check("abort_busy",   32'(bus.o_Busy),       32'd0);
    check("abort_ready",  32'(bus.o_Byte_Ready), 32'd0);
    check("abort_nwr",    32'(got_addr.size()),  32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    words = '{16'h0F0F, 16'hBEEF, 16'h0001};
    build_stream();
    run_load("fresh", stream.size());
    wait_end("fresh");
    compare_image("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
